fifo_uart_tx: RTL
=================

# fifo_uart_tx

Downstream drain stage for the 8-entry, 8-bit synchronous FIFO. It pops one byte at a time from the FIFO read port and shifts it out as an asynchronous serial frame: one start bit, 8 data bits LSB first, then 1 or 2 stop bits. The block owns the FIFO read enable and never reads when the FIFO reports empty, so the FIFO's empty flag throttles transmission.

## Interface
- CLKS_PER_BIT, 16: clk cycles per serial bit; legal range 2..65535.
- STOP_BITS, 1: number of stop bits; legal values 1 or 2.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  reset, synchronous, active-high.
- tx_en  input  1  permits new frames to start; a frame already in progress always completes.
- fifo_empty  input  1  FIFO empty flag.
- fifo_data  input  8  FIFO read data; valid the cycle after a pop.
- fifo_rd_en  output  1  FIFO pop request; combinational, high for exactly one cycle per byte.
- tx  output  1  serial line; idle high; registered.
- busy  output  1  high whenever state ≠ IDLE.
- frame_done  output  1  one-cycle pulse on the last stop-bit cycle; registered.
- frame_count  output  16  frames completed since reset; wraps 0xFFFF→0x0000.

## Operation
- States: IDLE, LOAD, START, DATA, STOP.
- IDLE
  - fifo_rd_en = tx_en & ~fifo_empty.
  - When it is high, next state is LOAD.
  - Otherwise the block stays in IDLE.
- LOAD
  - Lasts one cycle; fifo_rd_en = 0.
  - Captures fifo_data into the 8-bit shift register.
  - Next state is START.
- START
  - tx = 0 for CLKS_PER_BIT cycles, then next state is DATA.
- DATA
  - tx = shift[0] for CLKS_PER_BIT cycles per bit.
  - Shifts right after each bit; bit index 0..7.
  - After bit 7, next state is STOP.
- STOP
  - tx = 1 for STOP_BITS×CLKS_PER_BIT cycles.
  - frame_done pulses on the final cycle; frame_count increments on the same edge.
  - Next state is IDLE.
- Bit timer: a counter runs 0..CLKS_PER_BIT-1 and clears on every state change.
  - Width: clog2(CLKS_PER_BIT).
- The bit index is 3 bits; the stop-bit index is 1 bit.
- tx_en falling mid-frame has no effect until the frame returns to IDLE.
- fifo_empty is sampled only in IDLE.
- Captured data is unaffected by FIFO activity after LOAD.
- Reset values: state IDLE, tx=1, busy=0, frame_done=0, frame_count=0, shift=0x00, counters 0.
- fifo_rd_en is 0 during reset.
- Reset mid-frame: on the next edge tx=1 and state=IDLE; the byte in flight is discarded; the FIFO is not popped again for it.

## Timing
- Pop to line: fifo_rd_en high in cycle N, LOAD in N+1, tx falls at the edge ending N+1.
  - The first start-bit cycle is N+2.
- Frame length: (9+STOP_BITS)×CLKS_PER_BIT cycles from the first start cycle to the last stop cycle.
- Back-to-back frames with a non-empty FIFO: after the last stop cycle come one IDLE cycle (pop) and one LOAD cycle with tx=1.
  - Frame period = (9+STOP_BITS)×CLKS_PER_BIT + 2.
- busy rises at the edge ending the pop cycle.
  - It falls at the edge ending the last stop cycle, the same edge on which frame_done falls.
- fifo_rd_en is never asserted while fifo_empty=1, outside IDLE, or while reset=1.

## Test plan
- Reset with CLKS_PER_BIT=4 and FIFO empty, hold 20 cycles -> tx=1, busy=0, fifo_rd_en=0, frame_count=0 throughout.
- Push 0xA5, tx_en=1 -> one rd_en pulse.
  - tx shows 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles, with 40 cycles from start to stop end.
  - frame_done pulses once; frame_count=1.
- Push 0x01,0x80,0xFF, STOP_BITS=2 -> three frames, each 44 cycles, 2 cycles apart.
  - LSB first: 0x01 shows bit0=1 and rest 0; 0x80 shows bit7=1.
  - frame_count=3; exactly three rd_en pulses.
- tx_en=0 with FIFO holding 0x3C -> no rd_en and tx=1.
  - Raising tx_en starts the frame 2 cycles later.
  - Dropping tx_en mid-DATA still completes the 0x3C frame.
- Assert reset during DATA bit 3 of 0x55 -> tx=1 and busy=0 on the next edge; frame_count unchanged.
  - The following byte in the FIFO transmits intact after reset release.
- Preload frame_count to 0xFFFF via 65535 frames, or force in the bench, then send 1 frame -> frame_count=0x0000.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains an 8-bit FIFO one byte at a time and shifts each byte
// out as an asynchronous serial frame (start bit, 8 data bits LSB first,
// STOP_BITS stop bits). The FIFO empty flag throttles transmission because a
// new byte is only popped from IDLE when the FIFO has data and tx_en is high.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tx_en,
    input  logic        fifo_empty,
    input  logic [7:0]  fifo_data,
    output logic        fifo_rd_en,
    output logic        tx,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] frame_count
);

    // Bit timer wide enough to hold 0..CLKS_PER_BIT-1
    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TIMER_PRE  = TW'(CLKS_PER_BIT - 2);
    localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
    localparam logic          STOP_LAST  = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state;
    logic [7:0]    shift;
    logic [TW-1:0] timer;
    logic [2:0]    bit_idx;
    logic          stop_idx;
    logic          bit_end;

    assign bit_end = (timer == TIMER_LAST);

    // Pop only from IDLE, only when enabled and data is present, never in reset
    assign fifo_rd_en = (state == IDLE) && tx_en && !fifo_empty && !reset;

    // Any state other than IDLE means a frame is being loaded or shifted
    assign busy = (state != IDLE);

    // Frame sequencer: state, bit timer, shift register and registered line outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            tx          <= 1'b1;
            frame_done  <= 1'b0;
            frame_count <= 16'h0000;
            shift       <= 8'h00;
            timer       <= '0;
            bit_idx     <= 3'd0;
            stop_idx    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    timer <= '0;
                    tx    <= 1'b1;
                    if (fifo_rd_en) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    shift    <= fifo_data;
                    timer    <= '0;
                    bit_idx  <= 3'd0;
                    stop_idx <= 1'b0;
                    tx       <= 1'b0;
                    state    <= START;
                end
                START: begin
                    if (bit_end) begin
                        timer <= '0;
                        tx    <= shift[0];
                        state <= DATA;
                    end else begin
                        timer <= timer + TIMER_ONE;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        timer   <= '0;
                        shift   <= shift >> 1;
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            tx <= shift[1];
                        end
                    end else begin
                        timer <= timer + TIMER_ONE;
                    end
                end
                STOP: begin
                    tx <= 1'b1;
                    if (bit_end) begin
                        timer <= '0;
                        if (stop_idx == STOP_LAST) begin
                            frame_count <= frame_count + 16'd1;
                            state       <= IDLE;
                        end else begin
                            stop_idx <= stop_idx + 1'b1;
                        end
                    end else begin
                        timer <= timer + TIMER_ONE;
                        if ((stop_idx == STOP_LAST) && (timer == TIMER_PRE)) begin
                            frame_done <= 1'b1;
                        end
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    timer <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
